// File: rtl/maquina_estados_param.sv
// =============================================================================
// maquina_estados_param : flow-control FSM supervising a bank of NUM_FIFOS FIFOs
// Optional feature macro: MAQUINA_THRESH_CHECK_EN (rejects empty >= full thresholds)
// Revision: 1.0
// =============================================================================
`default_nettype none

module maquina_estados_param #(
  parameter int NUM_FIFOS = 8,
  parameter int PTR       = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init,
  input  logic [PTR-1:0]               full_threshold,
  input  logic [PTR-1:0]               empty_threshold,
  input  logic [NUM_FIFOS-1:0]         fifos_empty,
  input  logic [NUM_FIFOS-1:0]         fifos_error,
  input  logic [NUM_FIFOS*(PTR+1)-1:0] fifos_count,
  output logic [PTR-1:0]               fifos_full_threshold,
  output logic [PTR-1:0]               fifos_empty_threshold,
  output logic [NUM_FIFOS-1:0]         almost_full,
  output logic [NUM_FIFOS-1:0]         almost_empty,
  output logic                         idle,
  output logic                         error,
  output logic [NUM_FIFOS-1:0]         error_fifo,
  output logic [2:0]                   state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_load;
  logic                  w_thr_bad;
  logic                  w_all_empty;
  logic                  w_any_err;
  logic [PTR-1:0]        r_full_thr;
  logic [PTR-1:0]        r_empty_thr;
  logic [NUM_FIFOS-1:0]  r_almost_full;
  logic [NUM_FIFOS-1:0]  r_almost_empty;
  logic [NUM_FIFOS-1:0]  r_error_fifo;
  logic                  r_idle;
  logic                  r_error;
  logic [NUM_FIFOS-1:0]  w_af;
  logic [NUM_FIFOS-1:0]  w_ae;

  assign w_all_empty = &fifos_empty;
  assign w_any_err   = |fifos_error;

`ifdef MAQUINA_THRESH_CHECK_EN
  assign w_thr_bad = (empty_threshold >= full_threshold);
`else
  assign w_thr_bad = 1'b0;
`endif

  // Thresholds are zero-extended so a completely full FIFO (count == 2^PTR)
  // always compares as almost-full.
  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_flags
    logic [PTR:0] w_cnt;
    assign w_cnt   = fifos_count[i*(PTR+1) +: PTR+1];
    assign w_af[i] = (w_cnt >= {1'b0, r_full_thr});
    assign w_ae[i] = (w_cnt <= {1'b0, r_empty_thr});
  end

  always_comb begin
    w_next = S_RESET;
    w_load = 1'b0;
    case (r_state)
      S_RESET:  w_next = S_INIT;
      S_INIT: begin
        if (init) begin
          if (w_thr_bad) begin
            w_next = S_ERROR;
          end else begin
            w_next = S_INIT;
            w_load = 1'b1;
          end
        end else begin
          w_next = w_all_empty ? S_IDLE : S_ACTIVE;
        end
      end
      S_IDLE, S_ACTIVE: begin
        if (w_any_err)  w_next = S_ERROR;
        else if (init)  w_next = S_INIT;
        else            w_next = w_all_empty ? S_IDLE : S_ACTIVE;
      end
      S_ERROR:  w_next = init ? S_INIT : S_ERROR;
      default:  w_next = S_RESET;
    endcase
  end

  // All outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_RESET;
      r_full_thr     <= '0;
      r_empty_thr    <= '0;
      r_almost_full  <= '0;
      r_almost_empty <= '0;
      r_error_fifo   <= '0;
      r_idle         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_full_thr  <= full_threshold;
        r_empty_thr <= empty_threshold;
      end
      if (w_next == S_IDLE || w_next == S_ACTIVE) begin
        r_almost_full  <= w_af;
        r_almost_empty <= w_ae;
      end else begin
        r_almost_full  <= '0;
        r_almost_empty <= '0;
      end
      if (w_next == S_INIT)
        r_error_fifo <= '0;
      else if (r_state != S_RESET && r_state != S_INIT)
        r_error_fifo <= r_error_fifo | fifos_error;
      r_idle  <= (w_next == S_IDLE);
      r_error <= (w_next == S_ERROR);
    end
  end

  assign fifos_full_threshold  = r_full_thr;
  assign fifos_empty_threshold = r_empty_thr;
  assign almost_full           = r_almost_full;
  assign almost_empty          = r_almost_empty;
  assign error_fifo            = r_error_fifo;
  assign idle                  = r_idle;
  assign error                 = r_error;
  assign state                 = r_state;

endmodule

`default_nettype wire

// File: tb/tb_maquina_estados_param.sv
// Scoreboard bench for maquina_estados_param: directed vectors push expected
// post-edge values; a monitor pops and compares one entry per clock edge.
`default_nettype none

module tb_maquina_estados_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init = 1'b0;
  logic [2:0]  full_threshold = '0;
  logic [2:0]  empty_threshold = '0;
  logic [7:0]  fifos_empty = '0;
  logic [7:0]  fifos_error = '0;
  // FIFO7..FIFO0 = 4,4,4,4,4,8,1,7
  logic [31:0] fifos_count = 32'h4444_4817;
  logic [2:0]  fifos_full_threshold;
  logic [2:0]  fifos_empty_threshold;
  logic [7:0]  almost_full;
  logic [7:0]  almost_empty;
  logic        idle;
  logic        error;
  logic [7:0]  error_fifo;
  logic [2:0]  state;

  maquina_estados_param #(.NUM_FIFOS(8), .PTR(3)) dut (
    .clk(clk), .reset(reset), .init(init),
    .full_threshold(full_threshold), .empty_threshold(empty_threshold),
    .fifos_empty(fifos_empty), .fifos_error(fifos_error), .fifos_count(fifos_count),
    .fifos_full_threshold(fifos_full_threshold), .fifos_empty_threshold(fifos_empty_threshold),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .idle(idle), .error(error), .error_fifo(error_fifo), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [2:0] st;
    logic [2:0] tf;
    logic [2:0] te;
    logic [7:0] af;
    logic [7:0] ae;
    logic [7:0] ef;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step%0d %s actual=%h expected=%h", id, name, act, exp);
    end
  endtask

  task automatic step(input int id, input logic rs, input logic in,
                      input logic [2:0] f, input logic [2:0] e,
                      input logic [7:0] fe, input logic [7:0] fer,
                      input logic [2:0] st, input logic [2:0] tf, input logic [2:0] te,
                      input logic [7:0] af, input logic [7:0] ae, input logic [7:0] ef);
    exp_t x;
    @(negedge clk);
    reset = rs; init = in; full_threshold = f; empty_threshold = e;
    fifos_empty = fe; fifos_error = fer;
    x.id = id; x.st = st; x.tf = tf; x.te = te; x.af = af; x.ae = ae; x.ef = ef;
    q.push_back(x);
  endtask

  // Monitor: one DUT result per edge, compared against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("state", x.id, {5'd0, state}, {5'd0, x.st});
        chk("full_thr", x.id, {5'd0, fifos_full_threshold}, {5'd0, x.tf});
        chk("empty_thr", x.id, {5'd0, fifos_empty_threshold}, {5'd0, x.te});
        chk("almost_full", x.id, almost_full, x.af);
        chk("almost_empty", x.id, almost_empty, x.ae);
        chk("error_fifo", x.id, error_fifo, x.ef);
        chk("idle", x.id, {7'd0, idle}, {7'd0, (x.st == 3'd2)});
        chk("error", x.id, {7'd0, error}, {7'd0, (x.st == 3'd4)});
      end
    end
  end

  initial begin
    //     id rst init f     e     fe     ferr   | st  tf    te    af     ae     ef
    step(1,  0, 0, 3'd0, 3'd0, 8'h00, 8'h00,  3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
    step(2,  0, 0, 3'd0, 3'd0, 8'h00, 8'h00,  3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
    step(3,  1, 1, 3'd6, 3'd1, 8'h00, 8'h00,  3'd1, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
    step(4,  1, 1, 3'd6, 3'd1, 8'h00, 8'h00,  3'd1, 3'd6, 3'd1, 8'h00, 8'h00, 8'h00);
    step(5,  1, 0, 3'd0, 3'd0, 8'h00, 8'h00,  3'd3, 3'd6, 3'd1, 8'h05, 8'h02, 8'h00);
    step(6,  1, 0, 3'd0, 3'd0, 8'hFF, 8'h00,  3'd2, 3'd6, 3'd1, 8'h05, 8'h02, 8'h00);
    step(7,  1, 0, 3'd0, 3'd0, 8'hF7, 8'h00,  3'd3, 3'd6, 3'd1, 8'h05, 8'h02, 8'h00);
    step(8,  1, 1, 3'd0, 3'd0, 8'h00, 8'h10,  3'd4, 3'd6, 3'd1, 8'h00, 8'h00, 8'h10);
    step(9,  1, 0, 3'd0, 3'd0, 8'h00, 8'h00,  3'd4, 3'd6, 3'd1, 8'h00, 8'h00, 8'h10);
    step(10, 1, 1, 3'd0, 3'd0, 8'h00, 8'h00,  3'd1, 3'd6, 3'd1, 8'h00, 8'h00, 8'h00);
    step(11, 1, 0, 3'd0, 3'd0, 8'hFF, 8'h00,  3'd2, 3'd6, 3'd1, 8'h05, 8'h02, 8'h00);
    step(12, 1, 1, 3'd2, 3'd4, 8'hFF, 8'h00,  3'd1, 3'd6, 3'd1, 8'h00, 8'h00, 8'h00);
`ifdef MAQUINA_THRESH_CHECK_EN
    step(13, 1, 1, 3'd2, 3'd4, 8'hFF, 8'h00,  3'd4, 3'd6, 3'd1, 8'h00, 8'h00, 8'h00);
    step(14, 1, 0, 3'd0, 3'd0, 8'hFF, 8'h00,  3'd4, 3'd6, 3'd1, 8'h00, 8'h00, 8'h00);
    step(15, 1, 0, 3'd0, 3'd0, 8'hFF, 8'h10,  3'd4, 3'd6, 3'd1, 8'h00, 8'h00, 8'h10);
`else
    step(13, 1, 1, 3'd2, 3'd4, 8'hFF, 8'h00,  3'd1, 3'd2, 3'd4, 8'h00, 8'h00, 8'h00);
    step(14, 1, 0, 3'd0, 3'd0, 8'hFF, 8'h00,  3'd2, 3'd2, 3'd4, 8'hFD, 8'hFA, 8'h00);
    step(15, 1, 0, 3'd0, 3'd0, 8'hFF, 8'h10,  3'd4, 3'd2, 3'd4, 8'h00, 8'h00, 8'h10);
`endif
    step(16, 0, 1, 3'd5, 3'd1, 8'hFF, 8'h01,  3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
    step(17, 1, 0, 3'd0, 3'd0, 8'h00, 8'h00,  3'd1, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    init = 1'b0; fifos_error = '0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000;
    if (!done) begin
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
    end
  end

endmodule

`default_nettype wire
